sw_seq_decode: RTL

SW_SEQ_DECODE -- requirements
Module: sw_seq_decode

---
 rtl/sw_seq_decode.sv | 92 +++++++++
 1 files changed

// File: rtl/sw_seq_decode.sv
// Serial bit sequencer: captures a {len, pattern} word and presents its low
// len+1 bits one at a time on consumer request, optionally repeating the pass.
module sw_seq_decode #(
    parameter  int DATA_W    = 8,
    parameter  int MSB_FIRST = 1,
    localparam int LEN_W     = $clog2(DATA_W)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LEN_W+DATA_W-1:0] sw,
    input  logic                    load,
    input  logic                    next_bit,
    input  logic                    repeat_en,
    output logic                    bit_value,
    output logic                    bits_done,
    output logic                    busy,
    output logic [LEN_W-1:0]        bit_index
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_pattern;
    logic [DATA_W-1:0]   w_pattern_nxt;
    logic [LEN_W-1:0]    r_last;
    logic [LEN_W-1:0]    w_last_nxt;
    logic [LEN_W-1:0]    r_index;
    logic [LEN_W-1:0]    w_index_nxt;
    logic [LEN_W-1:0]    w_sel;
    logic                w_last_bit;

    // r_last holds L-1, which is exactly the captured len field
    assign w_last_bit = (r_index == r_last);

    always_comb begin
        w_state_nxt   = r_state;
        w_pattern_nxt = r_pattern;
        w_last_nxt    = r_last;
        w_index_nxt   = r_index;
        if (load) begin
            w_pattern_nxt = sw[DATA_W-1:0];
            w_last_nxt    = sw[LEN_W+DATA_W-1:DATA_W];
            w_index_nxt   = '0;
            w_state_nxt   = ACTIVE;
        end else if (r_state == ACTIVE && next_bit) begin
            if (!w_last_bit) begin
                w_index_nxt = r_index + LEN_W'(1);
            end else begin
                w_index_nxt = '0;
                if (!repeat_en) begin
                    w_state_nxt = DONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pattern <= '0;
            r_last    <= '0;
            r_index   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pattern <= w_pattern_nxt;
            r_last    <= w_last_nxt;
            r_index   <= w_index_nxt;
        end
    end

    // Index never exceeds r_last, so the subtraction cannot wrap
    always_comb begin
        if (MSB_FIRST != 0) begin
            w_sel = r_last - r_index;
        end else begin
            w_sel = r_index;
        end
    end

    always_comb begin
        busy      = (r_state == ACTIVE);
        bits_done = (r_state == DONE);
        bit_value = (r_state == ACTIVE) ? r_pattern[w_sel] : 1'b0;
        bit_index = (r_state == ACTIVE) ? r_index : '0;
    end

endmodule
